// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge
//   Byte buffer between the CPU bus and a UART core's byte handshake.
//   TX: CPU writes (wr_data/wr_en) are queued and launched one at a time
//       to the core (core_data_tx/core_have_data_tx), paced by
//       core_transmitting.
//   RX: bytes offered by the core (core_data_rx/core_have_data_rx) are
//       acked (core_data_rx_ack) and queued; the CPU reads the head
//       (rd_data, first-word-fall-through) and pops it with rd_en.
//   Status: tx_full/tx_count/tx_idle, rx_empty/rx_count, sticky rx_overrun
//   (cleared by overrun_clear).
module uart_fifo_bridge #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  tx_full,
  output logic [DEPTH_LOG2:0]   tx_count,
  output logic                  tx_idle,
  output logic [7:0]            rd_data,
  input  logic                  rd_en,
  output logic                  rx_empty,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic                  rx_overrun,
  input  logic                  overrun_clear,
  output logic [7:0]            core_data_tx,
  output logic                  core_have_data_tx,
  input  logic                  core_transmitting,
  input  logic [7:0]            core_data_rx,
  input  logic                  core_have_data_rx,
  output logic                  core_data_rx_ack
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

  logic [DEPTH-1:0][7:0] tx_mem_q, tx_mem_d, rx_mem_q, rx_mem_d;
  ptr_t tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  ptr_t rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  cnt_t tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [1:0] st_q, st_d;
  logic [7:0] dtx_q, dtx_d;
  logic       have_q, have_d;
  logic       ack_q, ack_d;
  logic       ovr_q, ovr_d;

  logic tx_full_w, tx_empty_w, rx_full_w, rx_empty_w;
  logic tx_push, tx_pop, rx_cap, rx_push, rx_pop, launch;

  // Full/empty come from start-of-cycle counts, so a pop never makes
  // room for a push in the same cycle.
  always_comb begin
    tx_full_w  = (tx_cnt_q == DEPTH_C);
    tx_empty_w = (tx_cnt_q == '0);
    rx_full_w  = (rx_cnt_q == DEPTH_C);
    rx_empty_w = (rx_cnt_q == '0);
    tx_push    = wr_en && !tx_full_w;
    launch     = (st_q == ST_IDLE) && !tx_empty_w && !core_transmitting;
    tx_pop     = launch;
    // While an ack is in flight the core's have flag is stale; skip it.
    rx_cap     = core_have_data_rx && !ack_q;
    rx_push    = rx_cap && !rx_full_w;
    rx_pop     = rd_en && !rx_empty_w;
  end

  always_comb begin
    tx_mem_d = tx_mem_q;
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    tx_cnt_d = tx_cnt_q + cnt_t'(tx_push) - cnt_t'(tx_pop);
    if (tx_push) begin
      tx_mem_d[tx_wp_q] = wr_data;
      tx_wp_d           = tx_wp_q + ptr_t'(1);
    end
    if (tx_pop) tx_rp_d = tx_rp_q + ptr_t'(1);

    rx_mem_d = rx_mem_q;
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    rx_cnt_d = rx_cnt_q + cnt_t'(rx_push) - cnt_t'(rx_pop);
    if (rx_push) begin
      rx_mem_d[rx_wp_q] = core_data_rx;
      rx_wp_d           = rx_wp_q + ptr_t'(1);
    end
    if (rx_pop) rx_rp_d = rx_rp_q + ptr_t'(1);

    ack_d = rx_cap;
    ovr_d = ovr_q;
    if (overrun_clear)      ovr_d = 1'b0;
    if (rx_cap && rx_full_w) ovr_d = 1'b1;  // set beats clear
  end

  // Launcher: strobe for one cycle, then wait out the core's busy window
  // before looking at the FIFO again.
  always_comb begin
    st_d   = st_q;
    dtx_d  = dtx_q;
    have_d = 1'b0;
    case (st_q)
      ST_IDLE: if (launch) begin
        dtx_d  = tx_mem_q[tx_rp_q];
        have_d = 1'b1;
        st_d   = ST_START;
      end
      ST_START: if (core_transmitting)  st_d = ST_BUSY;
      ST_BUSY:  if (!core_transmitting) st_d = ST_IDLE;
      default:  st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_mem_q <= '0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_mem_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      st_q     <= ST_IDLE;
      dtx_q    <= '0;
      have_q   <= 1'b0;
      ack_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      tx_mem_q <= tx_mem_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_mem_q <= rx_mem_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      st_q     <= st_d;
      dtx_q    <= dtx_d;
      have_q   <= have_d;
      ack_q    <= ack_d;
      ovr_q    <= ovr_d;
    end
  end

  assign tx_full           = tx_full_w;
  assign tx_count          = tx_cnt_q;
  assign tx_idle           = tx_empty_w && (st_q == ST_IDLE) && !core_transmitting;
  assign rd_data           = rx_mem_q[rx_rp_q];
  assign rx_empty          = rx_empty_w;
  assign rx_count          = rx_cnt_q;
  assign rx_overrun        = ovr_q;
  assign core_data_tx      = dtx_q;
  assign core_have_data_tx = have_q;
  assign core_data_rx_ack  = ack_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
module tb_uart_fifo_bridge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       tx_full;
  logic [3:0] tx_count;
  logic       tx_idle;
  logic [7:0] rd_data;
  logic       rd_en;
  logic       rx_empty;
  logic [3:0] rx_count;
  logic       rx_overrun;
  logic       overrun_clear;
  logic [7:0] core_data_tx;
  logic       core_have_data_tx;
  logic       core_transmitting;
  logic [7:0] core_data_rx;
  logic       core_have_data_rx;
  logic       core_data_rx_ack;

  int n_chk  = 0;
  int n_fail = 0;
  int strobe_cnt = 0;
  int ack_cnt    = 0;

  uart_fifo_bridge #(.DEPTH_LOG2(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_data(wr_data), .wr_en(wr_en),
    .tx_full(tx_full), .tx_count(tx_count), .tx_idle(tx_idle),
    .rd_data(rd_data), .rd_en(rd_en),
    .rx_empty(rx_empty), .rx_count(rx_count),
    .rx_overrun(rx_overrun), .overrun_clear(overrun_clear),
    .core_data_tx(core_data_tx), .core_have_data_tx(core_have_data_tx),
    .core_transmitting(core_transmitting),
    .core_data_rx(core_data_rx), .core_have_data_rx(core_have_data_rx),
    .core_data_rx_ack(core_data_rx_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (core_have_data_tx) strobe_cnt++;
    if (core_data_rx_ack)  ack_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Core offers one byte and holds have until it sees the ack.
  task automatic send_rx(input logic [7:0] b);
    bit seen = 0;
    @(negedge clk);
    core_data_rx = b;
    core_have_data_rx = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (core_data_rx_ack) begin seen = 1; break; end
    end
    core_have_data_rx = 1'b0;
    chk("rx_ack_seen", 32'(seen), 32'd1);
  endtask

  task automatic pop_rx;
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // Core byte 0x7E and a CPU pop land on the same capture edge.
  task automatic rx_with_pop(input logic clr);
    @(negedge clk);
    core_data_rx = 8'h7E;
    core_have_data_rx = 1'b1;
    rd_en = 1'b1;
    overrun_clear = clr;
    @(negedge clk);
    rd_en = 1'b0;
    overrun_clear = 1'b0;
    chk("rxpop_ack", 32'(core_data_rx_ack), 32'd1);
    core_have_data_rx = 1'b0;
    cyc(1);
  endtask

  // Waits for a launch strobe; returns how many idle negedges preceded it.
  task automatic wait_strobe(output int waited, output bit seen);
    seen = 0;
    waited = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (core_have_data_tx) begin seen = 1; waited = k; break; end
    end
  endtask

  initial begin
    int  w;
    bit  s;
    int  snap;
    rst_n = 1'b0;
    wr_data = '0; wr_en = 0; rd_en = 0; overrun_clear = 0;
    core_transmitting = 0; core_data_rx = '0; core_have_data_rx = 0;
    cyc(2);
    chk("rst_tx_full",  32'(tx_full), 32'd0);
    chk("rst_rx_empty", 32'(rx_empty), 32'd1);
    chk("rst_tx_idle",  32'(tx_idle), 32'd1);
    chk("rst_overrun",  32'(rx_overrun), 32'd0);
    chk("rst_have_tx",  32'(core_have_data_tx), 32'd0);
    chk("rst_data_tx",  32'(core_data_tx), 32'h00);
    chk("rst_ack",      32'(core_data_rx_ack), 32'd0);
    chk("rst_rd_data",  32'(rd_data), 32'h00);
    chk("rst_counts",   {tx_count, rx_count}, 8'h00);
    rst_n = 1'b1;
    cyc(1);

    // Single byte, core idle
    wr_data = 8'h55; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    chk("t1_have_early", 32'(core_have_data_tx), 32'd0);
    chk("t1_count1", 32'(tx_count), 32'd1);
    @(negedge clk);
    chk("t1_have", 32'(core_have_data_tx), 32'd1);
    chk("t1_data", 32'(core_data_tx), 32'h55);
    chk("t1_count0", 32'(tx_count), 32'd0);
    core_transmitting = 1'b1;
    @(negedge clk);
    chk("t1_have_pulse", 32'(core_have_data_tx), 32'd0);
    chk("t1_not_idle", 32'(tx_idle), 32'd0);
    @(negedge clk);
    core_transmitting = 1'b0;
    @(negedge clk);
    chk("t1_idle", 32'(tx_idle), 32'd1);

    // Nine writes with the core busy: eight kept, ninth dropped
    core_transmitting = 1'b1;
    cyc(1);
    for (int i = 1; i <= 9; i++) begin
      wr_data = 8'(i); wr_en = 1'b1;
      @(negedge clk);
      if (i == 8) chk("t2_full_at8", 32'(tx_full), 32'd1);
    end
    wr_en = 1'b0;
    chk("t2_count", 32'(tx_count), 32'd8);
    snap = strobe_cnt;
    for (int i = 1; i <= 8; i++) begin
      core_transmitting = 1'b0;
      wait_strobe(w, s);
      chk("t2_strobe_seen", 32'(s), 32'd1);
      chk("t2_launch_gap", 32'(w), (i == 1) ? 32'd0 : 32'd1);
      chk("t2_data", 32'(core_data_tx), 32'(i));
      chk("t2_count_dec", 32'(tx_count), 32'(8 - i));
      core_transmitting = 1'b1;
      @(negedge clk);
      chk("t2_have_pulse", 32'(core_have_data_tx), 32'd0);
      @(negedge clk);
    end
    core_transmitting = 1'b0;
    cyc(5);
    chk("t2_strobes", 32'(strobe_cnt - snap), 32'd8);
    chk("t2_idle", 32'(tx_idle), 32'd1);

    // Single RX byte
    snap = ack_cnt;
    send_rx(8'hA3);
    cyc(2);
    chk("t3_acks", 32'(ack_cnt - snap), 32'd1);
    chk("t3_count", 32'(rx_count), 32'd1);
    chk("t3_rd_data", 32'(rd_data), 32'hA3);
    pop_rx();
    chk("t3_empty", 32'(rx_empty), 32'd1);

    // Nine RX bytes, no reads
    snap = ack_cnt;
    for (int i = 0; i < 9; i++) send_rx(8'h10 + 8'(i));
    cyc(2);
    chk("t4_acks", 32'(ack_cnt - snap), 32'd9);
    chk("t4_count", 32'(rx_count), 32'd8);
    chk("t4_overrun", 32'(rx_overrun), 32'd1);
    chk("t4_head", 32'(rd_data), 32'h10);
    overrun_clear = 1'b1;
    @(negedge clk);
    overrun_clear = 1'b0;
    chk("t4_clear", 32'(rx_overrun), 32'd0);

    // Full FIFO: pop and incoming byte together; clear coincides with set
    rx_with_pop(1'b1);
    chk("t5_full_count", 32'(rx_count), 32'd7);
    chk("t5_full_ovr", 32'(rx_overrun), 32'd1);
    chk("t5_full_head", 32'(rd_data), 32'h11);
    repeat (4) pop_rx();
    chk("t5_count3", 32'(rx_count), 32'd3);
    chk("t5_head15", 32'(rd_data), 32'h15);
    rx_with_pop(1'b0);
    chk("t5_mid_count", 32'(rx_count), 32'd3);
    chk("t5_mid_head", 32'(rd_data), 32'h16);
    repeat (2) pop_rx();
    chk("t5_7e_head", 32'(rd_data), 32'h7E);
    chk("t5_7e_count", 32'(rx_count), 32'd1);

    // Reset while the launcher sits in START with a byte still queued
    wr_data = 8'hC1; wr_en = 1'b1;
    @(negedge clk);
    wr_data = 8'hC2;
    @(negedge clk);
    wr_en = 1'b0;
    chk("t6_launched", 32'(core_have_data_tx), 32'd1);
    chk("t6_queued", 32'(tx_count), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_have_rst", 32'(core_have_data_tx), 32'd0);
    chk("t6_data_rst", 32'(core_data_tx), 32'h00);
    chk("t6_count_rst", 32'(tx_count), 32'd0);
    chk("t6_rx_rst", 32'(rx_empty), 32'd1);
    snap = strobe_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(5);
    chk("t6_no_strobe", 32'(strobe_cnt - snap), 32'd0);
    chk("t6_idle", 32'(tx_idle), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
